// File: rtl/regfile_pkg.sv
// Shared register-file definitions: default widths, register count and the
// write-request payload used by both the arbiter and the register file side.
package regfile_pkg;

    localparam int unsigned RF_ADDR_W = 4;
    localparam int unsigned RF_DATA_W = 16;
    localparam int unsigned NUM_REGS  = 1 << RF_ADDR_W;

    typedef struct packed {
        logic                 valid;
        logic [RF_ADDR_W-1:0] addr;
        logic [RF_DATA_W-1:0] data;
    } wr_req_t;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: the first requester at or above ptr (wrapping modulo
// NUM_REQ) wins, and it is reported both one-hot and as an index.
module rr_arbiter #(
    parameter int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic               enable,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   grant_idx
);

    logic        found;
    int unsigned idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        idx       = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = 32'(ptr) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            if (enable && !found && req[IDX_W'(idx)]) begin
                found                 = 1'b1;
                grant[IDX_W'(idx)]    = 1'b1;
                grant_idx             = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Round-robin sharing of the register file write port among NUM_REQ sources,
// with a registered write stage, in-flight mask and contention counter.
module regfile_write_arbiter
    import regfile_pkg::*;
#(
    parameter int unsigned NUM_REQ = 3,
    parameter int unsigned DATA_W  = RF_DATA_W,
    parameter int unsigned ADDR_W  = RF_ADDR_W,
    localparam int unsigned IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int unsigned N_REGS = 1 << ADDR_W
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      hold,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic                      rf_reg_write,
    output logic [ADDR_W-1:0]         rf_write_reg,
    output logic [DATA_W-1:0]         rf_write_data,
    output logic [N_REGS-1:0]         inflight_mask,
    output logic [15:0]               contention_cnt
);

    logic [IDX_W-1:0]  rr_ptr;
    logic [IDX_W-1:0]  ptr_next;
    logic [NUM_REQ-1:0] grant;
    logic [IDX_W-1:0]  grant_idx;
    logic              granted;
    logic              multi_valid;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;

    // Reset gates the grant so no source sees ready while the block is held in reset.
    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
        .req       (req_valid),
        .enable    (!hold && !reset),
        .ptr       (rr_ptr),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign req_ready = grant;
    assign granted   = |grant;

    // Clearing the lowest set bit leaves something only when two or more are set.
    assign multi_valid = |(req_valid & (req_valid - NUM_REQ'(1)));

    always_comb begin
        ptr_next = (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + IDX_W'(1);
    end

    always_comb begin
        sel_addr = '0;
        sel_data = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant[i]) begin
                sel_addr = req_addr[i*ADDR_W +: ADDR_W];
                sel_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr         <= '0;
            rf_reg_write   <= 1'b0;
            rf_write_reg   <= '0;
            rf_write_data  <= '0;
            contention_cnt <= '0;
        end else begin
            rf_reg_write <= granted;
            if (granted) begin
                rr_ptr        <= ptr_next;
                rf_write_reg  <= sel_addr;
                rf_write_data <= sel_data;
            end
            if (!hold && multi_valid && (contention_cnt != 16'hFFFF)) begin
                contention_cnt <= contention_cnt + 16'd1;
            end
        end
    end

    // Marks the register whose write is on the port but not yet stored.
    always_comb begin
        inflight_mask = '0;
        if (rf_reg_write) begin
            inflight_mask[rf_write_reg] = 1'b1;
        end
    end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed self-checking bench for regfile_write_arbiter (3 sources, 16x16 RF).
module tb_regfile_write_arbiter;

    logic        clk;
    logic        reset;
    logic        hold;
    logic [2:0]  req_valid;
    logic [11:0] req_addr;
    logic [47:0] req_data;
    logic [2:0]  req_ready;
    logic        rf_reg_write;
    logic [3:0]  rf_write_reg;
    logic [15:0] rf_write_data;
    logic [15:0] inflight_mask;
    logic [15:0] contention_cnt;

    int total;
    int bad;

    regfile_write_arbiter #(.NUM_REQ(3), .DATA_W(16), .ADDR_W(4)) dut (
        .clk            (clk),
        .reset          (reset),
        .hold           (hold),
        .req_valid      (req_valid),
        .req_addr       (req_addr),
        .req_data       (req_data),
        .req_ready      (req_ready),
        .rf_reg_write   (rf_reg_write),
        .rf_write_reg   (rf_write_reg),
        .rf_write_data  (rf_write_data),
        .inflight_mask  (inflight_mask),
        .contention_cnt (contention_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_src(input int i, input logic [3:0] a, input logic [15:0] d);
        req_addr[i*4 +: 4]   = a;
        req_data[i*16 +: 16] = d;
    endtask

    // One reset edge, leaving the bench at a falling edge.
    task automatic do_reset();
        reset = 1'b1; req_valid = 3'b000; hold = 1'b0;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = 3'b111; hold = 1'b0;
        #1;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL reset_ready got=%b exp=000", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", rf_reg_write); end
        total++; if (rf_write_reg !== 4'h0) begin bad++; $display("FAIL reset_reg got=%h exp=0", rf_write_reg); end
        total++; if (rf_write_data !== 16'h0) begin bad++; $display("FAIL reset_data got=%h exp=0", rf_write_data); end
        total++; if (inflight_mask !== 16'h0) begin bad++; $display("FAIL reset_mask got=%h exp=0", inflight_mask); end
        total++; if (contention_cnt !== 16'h0) begin bad++; $display("FAIL reset_cnt got=%h exp=0", contention_cnt); end
        total++; if (dut.rr_ptr !== 2'd0) begin bad++; $display("FAIL reset_ptr got=%0d exp=0", dut.rr_ptr); end
        @(negedge clk);
        reset = 1'b0; req_valid = 3'b000;
    endtask

    task automatic test_single();
        set_src(0, 4'h5, 16'hA5A5);
        req_valid = 3'b001;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL single_ready got=%b exp=001", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b1) begin bad++; $display("FAIL single_we got=%b exp=1", rf_reg_write); end
        total++; if (rf_write_reg !== 4'h5) begin bad++; $display("FAIL single_reg got=%h exp=5", rf_write_reg); end
        total++; if (rf_write_data !== 16'hA5A5) begin bad++; $display("FAIL single_data got=%h exp=a5a5", rf_write_data); end
        total++; if (inflight_mask !== 16'h0020) begin bad++; $display("FAIL single_mask got=%h exp=0020", inflight_mask); end
        @(negedge clk);
        req_valid = 3'b000;
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b0) begin bad++; $display("FAIL idle_we got=%b exp=0", rf_reg_write); end
        total++; if (rf_write_reg !== 4'h5 || rf_write_data !== 16'hA5A5) begin
            bad++; $display("FAIL idle_keep got=%h/%h exp=5/a5a5", rf_write_reg, rf_write_data); end
        total++; if (inflight_mask !== 16'h0) begin bad++; $display("FAIL idle_mask got=%h exp=0", inflight_mask); end
        total++; if (contention_cnt !== 16'h0) begin bad++; $display("FAIL single_cnt got=%h exp=0", contention_cnt); end
        @(negedge clk);
    endtask

    task automatic test_contention();
        logic [2:0]  exp_rdy  [6] = '{3'b001, 3'b010, 3'b100, 3'b001, 3'b010, 3'b100};
        logic [3:0]  exp_reg  [6] = '{4'h5, 4'h3, 4'h9, 4'h5, 4'h3, 4'h9};
        logic [15:0] exp_data [6] = '{16'hA5A5, 16'h1234, 16'hBEEF, 16'hA5A5, 16'h1234, 16'hBEEF};
        logic [15:0] exp_mask;
        do_reset();
        set_src(0, 4'h5, 16'hA5A5);
        set_src(1, 4'h3, 16'h1234);
        set_src(2, 4'h9, 16'hBEEF);
        for (int k = 0; k < 6; k++) begin
            req_valid = 3'b111;
            #1;
            total++; if (req_ready !== exp_rdy[k]) begin bad++; $display("FAIL cont_ready[%0d] got=%b exp=%b", k, req_ready, exp_rdy[k]); end
            @(posedge clk); #1;
            exp_mask = 16'h0001 << exp_reg[k];
            total++; if (rf_reg_write !== 1'b1 || rf_write_reg !== exp_reg[k] || rf_write_data !== exp_data[k]) begin
                bad++; $display("FAIL cont_write[%0d] got=%b/%h/%h exp=1/%h/%h", k, rf_reg_write, rf_write_reg, rf_write_data, exp_reg[k], exp_data[k]); end
            total++; if (inflight_mask !== exp_mask) begin bad++; $display("FAIL cont_mask[%0d] got=%h exp=%h", k, inflight_mask, exp_mask); end
            total++; if (contention_cnt !== 16'(k + 1)) begin bad++; $display("FAIL cont_cnt[%0d] got=%0d exp=%0d", k, contention_cnt, k + 1); end
            @(negedge clk);
        end
    endtask

    // Pointer starts at 0; one grant moves it to 1, then hold must freeze it there.
    task automatic test_hold();
        req_valid = 3'b111; hold = 1'b0;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL hold_pre_ready got=%b exp=001", req_ready); end
        @(posedge clk);
        @(negedge clk);
        hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL hold_ready[%0d] got=%b exp=000", k, req_ready); end
            @(posedge clk); #1;
            total++; if (rf_reg_write !== 1'b0) begin bad++; $display("FAIL hold_we[%0d] got=%b exp=0", k, rf_reg_write); end
            total++; if (dut.rr_ptr !== 2'd1) begin bad++; $display("FAIL hold_ptr[%0d] got=%0d exp=1", k, dut.rr_ptr); end
            total++; if (contention_cnt !== 16'd7) begin bad++; $display("FAIL hold_cnt[%0d] got=%0d exp=7", k, contention_cnt); end
            @(negedge clk);
        end
        hold = 1'b0;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL hold_release_ready got=%b exp=010", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b1 || rf_write_reg !== 4'h3) begin
            bad++; $display("FAIL hold_release_write got=%b/%h exp=1/3", rf_reg_write, rf_write_reg); end
        total++; if (contention_cnt !== 16'd8) begin bad++; $display("FAIL hold_release_cnt got=%0d exp=8", contention_cnt); end
        @(negedge clk);
    endtask

    task automatic test_sparse();
        req_valid = 3'b100;
        #1;
        total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL sparse_ready2 got=%b exp=100", req_ready); end
        @(posedge clk);
        @(negedge clk);
        req_valid = 3'b010;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL sparse_ready1 got=%b exp=010", req_ready); end
        @(posedge clk); #1;
        total++; if (dut.rr_ptr !== 2'd2) begin bad++; $display("FAIL sparse_ptr got=%0d exp=2", dut.rr_ptr); end
        @(negedge clk);
        req_valid = 3'b101;
        #1;
        total++; if (req_ready !== 3'b100) begin bad++; $display("FAIL sparse_ready_wrap got=%b exp=100", req_ready); end
        @(posedge clk); #1;
        total++; if (contention_cnt !== 16'd9) begin bad++; $display("FAIL sparse_cnt got=%0d exp=9", contention_cnt); end
        @(negedge clk);
        req_valid = 3'b000;
    endtask

    // Two sources to the same register: both land, in grant order.
    task automatic test_back_to_back();
        set_src(0, 4'h7, 16'h0AAA);
        set_src(1, 4'h7, 16'h0BBB);
        req_valid = 3'b011;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL b2b_ready0 got=%b exp=001", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b1 || rf_write_reg !== 4'h7 || rf_write_data !== 16'h0AAA) begin
            bad++; $display("FAIL b2b_first got=%b/%h/%h exp=1/7/0aaa", rf_reg_write, rf_write_reg, rf_write_data); end
        @(negedge clk);
        req_valid = 3'b010;
        #1;
        total++; if (req_ready !== 3'b010) begin bad++; $display("FAIL b2b_ready1 got=%b exp=010", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b1 || rf_write_reg !== 4'h7 || rf_write_data !== 16'h0BBB) begin
            bad++; $display("FAIL b2b_second got=%b/%h/%h exp=1/7/0bbb", rf_reg_write, rf_write_reg, rf_write_data); end
        total++; if (inflight_mask !== 16'h0080) begin bad++; $display("FAIL b2b_mask got=%h exp=0080", inflight_mask); end
        total++; if (contention_cnt !== 16'd10) begin bad++; $display("FAIL b2b_cnt got=%0d exp=10", contention_cnt); end
        @(negedge clk);
        req_valid = 3'b000;
    endtask

    task automatic test_reset_mid();
        // rr_ptr is 2 here; only source 0 valid so it wins after wrap.
        set_src(0, 4'hC, 16'h5555);
        req_valid = 3'b001;
        #1;
        total++; if (req_ready !== 3'b001) begin bad++; $display("FAIL rmid_ready got=%b exp=001", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b1 || inflight_mask !== 16'h1000) begin
            bad++; $display("FAIL rmid_pending got=%b/%h exp=1/1000", rf_reg_write, inflight_mask); end
        @(negedge clk);
        reset = 1'b1; req_valid = 3'b111;
        #1;
        total++; if (req_ready !== 3'b000) begin bad++; $display("FAIL rmid_ready_in_reset got=%b exp=000", req_ready); end
        @(posedge clk); #1;
        total++; if (rf_reg_write !== 1'b0 || rf_write_reg !== 4'h0 || rf_write_data !== 16'h0 || inflight_mask !== 16'h0) begin
            bad++; $display("FAIL rmid_outputs got=%b/%h/%h/%h exp=0/0/0/0", rf_reg_write, rf_write_reg, rf_write_data, inflight_mask); end
        total++; if (contention_cnt !== 16'h0 || dut.rr_ptr !== 2'd0) begin
            bad++; $display("FAIL rmid_state got=%0d/%0d exp=0/0", contention_cnt, dut.rr_ptr); end
        @(negedge clk);
        reset = 1'b0; req_valid = 3'b000;
    endtask

    task automatic test_saturation();
        do_reset();
        req_valid = 3'b011;
        for (int k = 0; k < 65534; k++) @(posedge clk);
        #1;
        total++; if (contention_cnt !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", contention_cnt); end
        @(posedge clk); #1;
        total++; if (contention_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_reach got=%h exp=ffff", contention_cnt); end
        for (int k = 0; k < 5; k++) @(posedge clk);
        #1;
        total++; if (contention_cnt !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", contention_cnt); end
        @(negedge clk);
        req_valid = 3'b000;
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b1; hold = 1'b0; req_valid = 3'b000;
        req_addr = '0; req_data = '0;
        @(negedge clk);
        test_reset();
        test_single();
        test_contention();
        test_hold();
        test_sparse();
        test_back_to_back();
        test_reset_mid();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
